// File: rtl/inst_queue_pkg.sv
// Shared types for the IF->ID instruction queue: the 96-bit entry layout and a packing helper.
package inst_queue_pkg;

  localparam int INST_BUS   = 32;
  localparam int PC_BUS     = 32;
  localparam int IQ_ENTRY_W = 96;
  localparam int IQ_INST    = 0;
  localparam int IQ_NPC     = 32;
  localparam int IQ_PC      = 64;

  // Field order matches the offsets above: pc [95:64], npc [63:32], inst [31:0].
  typedef struct packed {
    logic [PC_BUS-1:0]   pc;
    logic [PC_BUS-1:0]   npc;
    logic [INST_BUS-1:0] inst;
  } iq_entry_t;

  function automatic iq_entry_t iq_pack(input logic [PC_BUS-1:0] pc,
                                        input logic [PC_BUS-1:0] npc,
                                        input logic [INST_BUS-1:0] inst);
    iq_entry_t e;
    e.pc   = pc;
    e.npc  = npc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push bus and decode-side pop bus of the instruction queue.
// Handshake: a push is taken on a clock edge when in_ready=1 and in_valid!=0; decode takes
// out_pop (<= number of set out_valid bits) head entries on the same edge. No same-cycle credit.
interface inst_queue_if #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
) ();
  localparam int PTR_W = $clog2(DEPTH);
  localparam int POP_W = $clog2(OUT_W + 1);

  logic [IN_W-1:0]     in_valid;
  logic [IN_W*32-1:0]  in_inst;
  logic [IN_W*32-1:0]  in_pc;
  logic [IN_W*32-1:0]  in_npc;
  logic                in_ready;
  logic [OUT_W-1:0]    out_valid;
  logic [OUT_W*32-1:0] out_inst;
  logic [OUT_W*32-1:0] out_pc;
  logic [OUT_W*32-1:0] out_npc;
  logic [POP_W-1:0]    out_pop;
  logic [PTR_W:0]      count;

  modport slave (
    input  in_valid, in_inst, in_pc, in_npc, out_pop,
    output in_ready, out_valid, out_inst, out_pc, out_npc, count
  );

  modport master (
    output in_valid, in_inst, in_pc, in_npc, out_pop,
    input  in_ready, out_valid, out_inst, out_pc, out_npc, count
  );
endinterface

// File: rtl/inst_queue_lane_mux.sv
// Head-relative read muxes: lane k shows entry (head+k) mod DEPTH while k < count, else zero.
module inst_queue_lane_mux
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OUT_W = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  iq_entry_t [DEPTH-1:0] mem_i,
  input  logic [PTR_W-1:0]      head_i,
  input  logic [PTR_W:0]        count_i,
  output logic [OUT_W-1:0]      valid_o,
  output logic [OUT_W*32-1:0]   pc_o,
  output logic [OUT_W*32-1:0]   npc_o,
  output logic [OUT_W*32-1:0]   inst_o
);

  always_comb begin
    valid_o = '0;
    pc_o    = '0;
    npc_o   = '0;
    inst_o  = '0;
    for (int k = 0; k < OUT_W; k++) begin
      logic [PTR_W-1:0] rd_addr;
      iq_entry_t        e;
      // Address wraps by truncation, so reads straddling DEPTH-1 -> 0 need no special case.
      rd_addr = head_i + PTR_W'(k);
      e       = mem_i[rd_addr];
      if ((PTR_W+1)'(k) < count_i) begin
        valid_o[k]        = 1'b1;
        pc_o[32*k +: 32]   = e.pc;
        npc_o[32*k +: 32]  = e.npc;
        inst_o[32*k +: 32] = e.inst;
      end
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Circular multi-lane instruction queue between fetch and decode, with flush and
// registered-count backpressure.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  inst_queue_if.slave  iq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      npush, npop, pop_req;
  logic                  in_ready;
  logic                  push_en;

  function automatic logic [CNT_W-1:0] popcnt(input logic [IN_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Room is judged on the registered count only, so IF never depends on decode's pop.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_W);
  assign push_en  = in_ready && (|iq.in_valid) && !flush;
  assign npush    = push_en ? popcnt(iq.in_valid) : '0;
  assign pop_req  = CNT_W'(iq.out_pop);
  assign npop     = flush ? '0 : ((pop_req > count_q) ? count_q : pop_req);

  always_comb begin
    head_d  = head_q + PTR_W'(npop);
    tail_d  = tail_q + PTR_W'(npush);
    count_d = count_q + npush - npop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: lanes beyond count are masked to zero on read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (push_en && (CNT_W'(i) < npush)) begin
        mem_q[tail_q + PTR_W'(i)] <= iq_pack(iq.in_pc[32*i +: 32],
                                             iq.in_npc[32*i +: 32],
                                             iq.in_inst[32*i +: 32]);
      end
    end
  end

  inst_queue_lane_mux #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W),
    .PTR_W (PTR_W)
  ) u_lane_mux (
    .mem_i   (mem_q),
    .head_i  (head_q),
    .count_i (count_q),
    .valid_o (iq.out_valid),
    .pc_o    (iq.out_pc),
    .npc_o   (iq.out_npc),
    .inst_o  (iq.out_inst)
  );

  assign iq.in_ready = in_ready;
  assign iq.count    = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomized run against a queue model.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  logic flush;
  int   total;
  int   bad;

  // Reference model: oldest entry at index 0, each entry {pc, npc, inst}.
  logic [95:0] exp_q[$];

  inst_queue_if #(.DEPTH(DEPTH), .IN_W(2), .OUT_W(2)) q_if ();

  inst_queue #(.DEPTH(DEPTH), .IN_W(2), .OUT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .iq    (q_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, advances the model by the queue's rules, returns at the next negedge.
  task automatic drive(input logic f, input logic [1:0] v, input int pop, input logic [31:0] pc0);
    logic [31:0] lp[2];
    logic [31:0] ln[2];
    logic [31:0] li[2];
    int          sz;
    int          np;
    logic        rdy;
    for (int i = 0; i < 2; i++) begin
      lp[i] = pc0 + 32'(4 * i);
      ln[i] = lp[i] + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h4);
      li[i] = $urandom;
    end
    flush          = f;
    q_if.in_valid  = v;
    q_if.out_pop   = 2'(pop);
    q_if.in_pc     = {lp[1], lp[0]};
    q_if.in_npc    = {ln[1], ln[0]};
    q_if.in_inst   = {li[1], li[0]};
    sz  = exp_q.size();
    rdy = (DEPTH - sz) >= 2;
    if (!f) assert (pop <= sz) else $error("protocol: out_pop %0d exceeds occupancy %0d", pop, sz);
    assert (v != 2'b10) else $error("protocol: in_valid has a hole");
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      np = (pop < sz) ? pop : sz;
      repeat (np) void'(exp_q.pop_front());
      if (rdy)
        for (int i = 0; i < 2; i++)
          if (v[i]) exp_q.push_back({lp[i], ln[i], li[i]});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) drive(1'b0, 2'b00, (exp_q.size() > 1) ? 2 : 1, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    q_if.in_valid = '0;
    q_if.out_pop  = '0;
    q_if.in_pc    = '0;
    q_if.in_npc   = '0;
    q_if.in_inst  = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    total++;
    if (q_if.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", q_if.count); end
    total++;
    if (q_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", q_if.in_ready); end
    total++;
    if (q_if.out_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", q_if.out_valid); end
    total++;
    if ({q_if.out_pc, q_if.out_npc, q_if.out_inst} !== 192'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {q_if.out_pc, q_if.out_npc, q_if.out_inst});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_push();
    drive(1'b0, 2'b11, 0, 32'h100);
    total++;
    if (q_if.out_valid !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b exp=11", q_if.out_valid); end
    total++;
    if (q_if.out_pc !== {32'h104, 32'h100}) begin bad++; $display("FAIL basic_pc got=%h exp=%h", q_if.out_pc, {32'h104, 32'h100}); end
    total++;
    if (q_if.count !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", q_if.count); end
    total++;
    if ({q_if.out_npc[31:0], q_if.out_inst[31:0]} !== exp_q[0][63:0]) begin
      bad++; $display("FAIL basic_lane0 got=%h exp=%h", {q_if.out_npc[31:0], q_if.out_inst[31:0]}, exp_q[0][63:0]);
    end
  endtask

  task automatic test_fill();
    int exp_cnt[5] = '{2, 4, 6, 8, 8};
    drain();
    for (int j = 0; j < 5; j++) begin
      total++;
      if (q_if.in_ready !== (j < 4)) begin bad++; $display("FAIL fill_ready step=%0d got=%b exp=%b", j, q_if.in_ready, j < 4); end
      drive(1'b0, 2'b11, 0, 32'h1000 + 32'(8 * j));
      total++;
      if (q_if.count !== 4'(exp_cnt[j])) begin bad++; $display("FAIL fill_count step=%0d got=%0d exp=%0d", j, q_if.count, exp_cnt[j]); end
    end
    total++;
    if (q_if.out_pc !== {32'h1004, 32'h1000}) begin bad++; $display("FAIL fill_head got=%h exp=%h", q_if.out_pc, {32'h1004, 32'h1000}); end
  endtask

  task automatic test_push_pop_full();
    drive(1'b0, 2'b11, 2, 32'h2000);
    total++;
    if (q_if.count !== 4'd6) begin bad++; $display("FAIL fullpp_count got=%0d exp=6", q_if.count); end
    total++;
    if (q_if.out_pc !== {32'h100C, 32'h1008}) begin bad++; $display("FAIL fullpp_head got=%h exp=%h", q_if.out_pc, {32'h100C, 32'h1008}); end
    total++;
    if (q_if.in_ready !== 1'b1) begin bad++; $display("FAIL fullpp_ready got=%b exp=1", q_if.in_ready); end
  endtask

  task automatic test_wrap();
    logic [31:0] last_pc;
    logic [31:0] pc;
    drain();
    pc      = 32'h4000;
    last_pc = 32'h0;
    for (int j = 0; j < 20; j++) begin
      drive(1'b0, 2'b01, (exp_q.size() > 2) ? 1 : 0, pc);
      pc = pc + 32'h4;
      total++;
      if (q_if.out_pc[31:0] !== exp_q[0][95:64]) begin bad++; $display("FAIL wrap_lane0 step=%0d got=%h exp=%h", j, q_if.out_pc[31:0], exp_q[0][95:64]); end
      total++;
      if (q_if.out_pc[31:0] < last_pc) begin bad++; $display("FAIL wrap_order step=%0d got=%h exp>=%h", j, q_if.out_pc[31:0], last_pc); end
      last_pc = q_if.out_pc[31:0];
      if (exp_q.size() > 1) begin
        total++;
        if (q_if.out_pc[63:32] !== q_if.out_pc[31:0] + 32'h4) begin
          bad++; $display("FAIL wrap_lane1 step=%0d got=%h exp=%h", j, q_if.out_pc[63:32], q_if.out_pc[31:0] + 32'h4);
        end
      end
    end
  endtask

  task automatic test_flush();
    drain();
    drive(1'b0, 2'b11, 0, 32'h5000);
    drive(1'b0, 2'b11, 0, 32'h5008);
    drive(1'b0, 2'b01, 0, 32'h5010);
    total++;
    if (q_if.count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", q_if.count); end
    drive(1'b1, 2'b11, 2, 32'h6000);
    total++;
    if (q_if.count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", q_if.count); end
    total++;
    if (q_if.out_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", q_if.out_valid); end
    total++;
    if (q_if.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", q_if.in_ready); end
    drive(1'b0, 2'b11, 0, 32'h300);
    total++;
    if (q_if.out_pc !== {32'h304, 32'h300}) begin bad++; $display("FAIL flush_after got=%h exp=%h", q_if.out_pc, {32'h304, 32'h300}); end
  endtask

  task automatic test_reset_mid();
    drain();
    drive(1'b0, 2'b11, 0, 32'h7000);
    drive(1'b0, 2'b01, 0, 32'h7008);
    total++;
    if (q_if.count !== 4'd3) begin bad++; $display("FAIL rstmid_pre got=%0d exp=3", q_if.count); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (q_if.count !== 4'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", q_if.count); end
    total++;
    if (q_if.out_valid !== 2'b00 || q_if.out_pc !== 64'h0) begin
      bad++; $display("FAIL rstmid_out got=%b/%h exp=00/0", q_if.out_valid, q_if.out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b01, 0, 32'h200);
    total++;
    if (q_if.out_valid !== 2'b01 || q_if.out_pc[31:0] !== 32'h200) begin
      bad++; $display("FAIL rstmid_push got=%b/%h exp=01/00000200", q_if.out_valid, q_if.out_pc[31:0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    int         maxpop;
    logic [95:0] lane;
    logic       ev;
    for (int j = 0; j < 400; j++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      maxpop = (exp_q.size() < 2) ? exp_q.size() : 2;
      drive(($urandom_range(0, 39) == 0), v, $urandom_range(0, maxpop), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      total++;
      if (q_if.count !== 4'(exp_q.size())) begin bad++; $display("FAIL rand_count step=%0d got=%0d exp=%0d", j, q_if.count, exp_q.size()); end
      total++;
      if (q_if.in_ready !== ((DEPTH - exp_q.size()) >= 2)) begin
        bad++; $display("FAIL rand_ready step=%0d got=%b exp=%b", j, q_if.in_ready, (DEPTH - exp_q.size()) >= 2);
      end
      for (int k = 0; k < 2; k++) begin
        ev   = k < exp_q.size();
        lane = ev ? exp_q[k] : 96'h0;
        total++;
        if (q_if.out_valid[k] !== ev ||
            {q_if.out_pc[32*k +: 32], q_if.out_npc[32*k +: 32], q_if.out_inst[32*k +: 32]} !== lane) begin
          bad++;
          $display("FAIL rand_lane%0d step=%0d got=%b/%h exp=%b/%h", k, j, q_if.out_valid[k],
                   {q_if.out_pc[32*k +: 32], q_if.out_npc[32*k +: 32], q_if.out_inst[32*k +: 32]}, ev, lane);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_push();
    test_fill();
    test_push_pop_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
